// File: rtl/rca_result_collector_pkg.sv
// Shared constants and helpers for the ripple-carry adder result collector.
// Default adder geometry matches the upstream pipelined adder.
package rca_result_collector_pkg;

  localparam int RCA_WIDTH   = 4;
  localparam int RCA_LATENCY = 4;

  // Number of set bits in a vector of up to 32 bits.
  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/rca_result_collector_chk.sv
// Protocol checker for the result collector: the credit scheme must make
// a write into a full result FIFO impossible.
module rca_result_collector_chk (
  input logic clock,
  input logic reset,
  input logic push,
  input logic full
);

  a_no_push_when_full: assert property (@(posedge clock) disable iff (reset) !(push && full));

endmodule

// File: rtl/rca_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry an extra MSB so
// full and empty are distinguished without a separate counter.
module rca_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop & ~empty;
  // A full FIFO can still accept a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rca_result_collector.sv
// Collects pipelined adder results: tracks valid issues, captures {cout,sum}
// after LATENCY cycles, keeps a running sum and buffers results behind credits.
module rca_result_collector
  import rca_result_collector_pkg::*;
#(
  parameter int WIDTH      = RCA_WIDTH,
  parameter int LATENCY    = RCA_LATENCY,
  parameter int ACC_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     sum,
  input  logic                 cout,
  input  logic                 clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH:0]       out_result,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic                 acc_ovf,
  output logic                 issue_err
);

  localparam int RW  = WIDTH + 1;
  localparam int AW1 = ACC_WIDTH + 1;
  localparam int EW  = RW + ACC_WIDTH;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  logic [LATENCY-1:0]   vld_pipe;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_base;
  logic [ACC_WIDTH:0]   acc_sum;
  logic [RW-1:0]        res;
  logic [5:0]           inflight;
  logic [CW-1:0]        occ;
  logic [EW-1:0]        head;
  logic                 issue;
  logic                 capture;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;

  assign inflight = popcount32(32'(vld_pipe));
  // Credits count both buffered results and adds still inside the adder.
  assign in_ready = (int'(occ) + int'(inflight)) < FIFO_DEPTH;
  assign issue    = in_valid & in_ready;
  assign capture  = vld_pipe[LATENCY-1];
  assign res      = {cout, sum};
  assign push     = capture;
  assign pop      = out_valid & out_ready;

  // Next accumulator value; a clear in the capture cycle takes effect before the add.
  always_comb begin
    acc_base = acc;
    if (clear) begin
      acc_base = '0;
    end else begin
      acc_base = acc;
    end
    acc_sum = {1'b0, acc_base} + AW1'(res);
  end

  // Valid shift register, running sum and sticky flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe  <= '0;
      acc       <= '0;
      acc_ovf   <= 1'b0;
      issue_err <= 1'b0;
    end else begin
      vld_pipe  <= (vld_pipe << 1'b1) | LATENCY'(issue);
      issue_err <= issue_err | (in_valid & ~in_ready);
      if (capture) begin
        acc     <= acc_sum[ACC_WIDTH-1:0];
        acc_ovf <= (acc_ovf & ~clear) | acc_sum[ACC_WIDTH];
      end else if (clear) begin
        acc     <= '0;
        acc_ovf <= 1'b0;
      end else begin
        acc     <= acc;
        acc_ovf <= acc_ovf;
      end
    end
  end

  rca_sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({res, acc_sum[ACC_WIDTH-1:0]}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (occ)
  );

  rca_result_collector_chk u_chk (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .full  (full)
  );

  assign out_valid  = ~empty;
  assign out_result = empty ? '0 : head[EW-1:ACC_WIDTH];
  assign out_acc    = empty ? '0 : head[ACC_WIDTH-1:0];

endmodule

// File: tb/tb_rca_result_collector.sv
// Bench for rca_result_collector with a behavioural LATENCY-stage adder upstream,
// directed scenarios plus a randomized run against a queue-based model.
module tb_rca_result_collector;

  localparam int L = 4;

  typedef struct packed {
    logic [4:0]  r;
    logic [15:0] a16;
    logic [7:0]  a8;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  a = 4'd0;
  logic [3:0]  b = 4'd0;
  logic        cin = 1'b0;
  logic [4:0]  pipe [L];
  logic [3:0]  sum;
  logic        cout;

  logic        in_ready, out_valid, acc_ovf, issue_err;
  logic [4:0]  out_result;
  logic [15:0] out_acc;
  logic        in_ready8, out_valid8, acc_ovf8, issue_err8;
  logic [4:0]  out_result8;
  logic [7:0]  out_acc8;

  int checks = 0;
  int passed = 0;

  assign sum  = pipe[L-1][3:0];
  assign cout = pipe[L-1][4];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    pipe[0] <= {1'b0, a} + {1'b0, b} + {4'd0, cin};
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end

  rca_result_collector #(.ACC_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .cout(cout), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_acc(out_acc), .acc_ovf(acc_ovf), .issue_err(issue_err));

  rca_result_collector #(.ACC_WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
    .sum(sum), .cout(cout), .clear(clear), .out_valid(out_valid8), .out_ready(out_ready),
    .out_result(out_result8), .out_acc(out_acc8), .acc_ovf(acc_ovf8), .issue_err(issue_err8));

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    in_valid = 1'b1;
    tick;
    do_reset;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else passed++;
    checks++; if (out_result !== 5'd0) $display("FAIL reset_out_result got %0d want 0", out_result); else passed++;
    checks++; if (out_acc !== 16'd0) $display("FAIL reset_out_acc got %0d want 0", out_acc); else passed++;
    checks++; if (out_acc8 !== 8'd0) $display("FAIL reset_out_acc8 got %0d want 0", out_acc8); else passed++;
    checks++; if (acc_ovf !== 1'b0) $display("FAIL reset_acc_ovf got %0b want 0", acc_ovf); else passed++;
    checks++; if (issue_err !== 1'b0) $display("FAIL reset_issue_err got %0b want 0", issue_err); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else passed++;
  endtask

  task automatic test_single;
    do_reset;
    out_ready = 1'b1;
    a = 4'd3; b = 4'd4; cin = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 1) in_valid = 1'b0;
      checks++; if (out_valid !== (c == 5)) $display("FAIL single_valid cycle %0d got %0b want %0b", c, out_valid, (c == 5)); else passed++;
      if (c == 5) begin
        checks++; if (out_result !== 5'd8) $display("FAIL single_result got %0d want 8", out_result); else passed++;
        checks++; if (out_acc !== 16'd8) $display("FAIL single_acc got %0d want 8", out_acc); else passed++;
      end
      tick;
    end
  endtask

  task automatic test_carry;
    do_reset;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 2);
      if (c == 0) begin a = 4'd15; b = 4'd15; cin = 1'b1; end
      if (c == 1) begin a = 4'd0;  b = 4'd0;  cin = 1'b0; end
      checks++; if (out_valid !== (c == 5 || c == 6)) $display("FAIL carry_valid cycle %0d got %0b", c, out_valid); else passed++;
      if (c == 5) begin
        checks++; if (out_result !== 5'd31 || out_acc !== 16'd31) $display("FAIL carry_first got %0d/%0d want 31/31", out_result, out_acc); else passed++;
      end
      if (c == 6) begin
        checks++; if (out_result !== 5'd0 || out_acc !== 16'd31) $display("FAIL carry_second got %0d/%0d want 0/31", out_result, out_acc); else passed++;
      end
      tick;
    end
  endtask

  task automatic test_backpressure;
    logic [4:0] exp_r [$];
    int ready_cnt;
    int run;
    do_reset;
    ready_cnt = 0;
    run = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      a = 4'($urandom); b = 4'($urandom); cin = 1'($urandom);
      if (c < 4) exp_r.push_back({1'b0, a} + {1'b0, b} + {4'd0, cin});
      if (in_ready) ready_cnt++;
      if (c == 4) begin
        checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_full got %0b want 0", in_ready); else passed++;
      end
      tick;
    end
    in_valid = 1'b0;
    checks++; if (ready_cnt != 4) $display("FAIL bp_accepted got %0d want 4", ready_cnt); else passed++;
    checks++; if (issue_err !== 1'b1) $display("FAIL bp_issue_err got %0b want 1", issue_err); else passed++;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        run = run + int'(exp_r[k]);
        checks++;
        if (out_valid !== 1'b1 || out_result !== exp_r[k] || out_acc !== 16'(run))
          $display("FAIL bp_drain_%0d got v=%0b r=%0d acc=%0d want v=1 r=%0d acc=%0d", k, out_valid, out_result, out_acc, exp_r[k], run);
        else passed++;
      end else begin
        checks++; if (out_valid !== 1'b0) $display("FAIL bp_empty got %0b want 0", out_valid); else passed++;
      end
      if (k == 0) begin
        checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready_at_pop got %0b want 0", in_ready); else passed++;
      end
      if (k == 1) begin
        checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after_pop got %0b want 1", in_ready); else passed++;
      end
      tick;
    end
  endtask

  task automatic test_wrap;
    int issued, popped, total;
    logic [7:0]  last8;
    logic [15:0] last16;
    logic        last_ovf;
    do_reset;
    issued = 0; popped = 0; last8 = 8'd0; last16 = 16'd0; last_ovf = 1'b0;
    total = 9 * (15 + 15 + 1);
    out_ready = 1'b1;
    a = 4'd15; b = 4'd15; cin = 1'b1;
    for (int c = 0; c < 80 && popped < 9; c++) begin
      in_valid = (issued < 9);
      if (in_valid && in_ready8) issued++;
      if (out_valid8) begin
        popped++; last8 = out_acc8; last16 = out_acc; last_ovf = acc_ovf8;
      end
      tick;
    end
    in_valid = 1'b0;
    checks++; if (popped != 9) $display("FAIL wrap_count got %0d want 9", popped); else passed++;
    checks++; if (last8 !== 8'(total % 256)) $display("FAIL wrap_acc8 got %0d want %0d", last8, total % 256); else passed++;
    checks++; if (last16 !== 16'(total)) $display("FAIL wrap_acc16 got %0d want %0d", last16, total); else passed++;
    checks++; if (last_ovf !== (total >= 256)) $display("FAIL wrap_ovf got %0b want 1", last_ovf); else passed++;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    checks++; if (acc_ovf8 !== 1'b0) $display("FAIL wrap_clear_ovf got %0b want 0", acc_ovf8); else passed++;
    a = 4'd1; b = 4'd1; cin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int c = 0; c < 10 && !out_valid8; c++) tick;
    checks++;
    if (out_valid8 !== 1'b1 || out_acc8 !== 8'd2 || acc_ovf8 !== 1'b0 || out_acc !== 16'd2)
      $display("FAIL wrap_after_clear got v=%0b acc8=%0d ovf=%0b acc16=%0d want 1/2/0/2", out_valid8, out_acc8, acc_ovf8, out_acc);
    else passed++;
  endtask

  task automatic test_clear_capture;
    logic [15:0] last;
    do_reset;
    last = 16'd0;
    out_ready = 1'b1;
    a = 4'd15; b = 4'd15; cin = 1'b1; in_valid = 1'b1;
    tick;
    a = 4'd9; b = 4'd9; cin = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) last = out_acc;
      tick;
    end
    checks++; if (last !== 16'd50) $display("FAIL clrcap_prior got %0d want 50", last); else passed++;
    a = 4'd2; b = 4'd2; cin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick; tick; tick;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 5'd4 || out_acc !== 16'd4)
      $display("FAIL clrcap_acc got v=%0b r=%0d acc=%0d want 1/4/4", out_valid, out_result, out_acc);
    else passed++;
  endtask

  task automatic test_reset_midflight;
    int seen;
    do_reset;
    seen = 0;
    out_ready = 1'b1;
    a = 4'd5; b = 4'd6; cin = 1'b0; in_valid = 1'b1;
    tick;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready got %0b want 1", in_ready); else passed++;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) seen++;
      tick;
    end
    checks++; if (seen != 0) $display("FAIL midrst_out_valid got %0d cycles want 0", seen); else passed++;
    checks++; if (out_acc !== 16'd0) $display("FAIL midrst_acc got %0d want 0", out_acc); else passed++;
  endtask

  task automatic test_random;
    exp_t q [$];
    exp_t e;
    int   m_acc;
    logic m_err;
    do_reset;
    m_acc = 0; m_err = 1'b0;
    for (int c = 0; c < 440; c++) begin
      a = 4'($urandom); b = 4'($urandom); cin = 1'($urandom);
      in_valid  = (c < 400) ? ($urandom_range(0, 3) != 0) : 1'b0;
      out_ready = (c < 400) ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clock);
      checks++;
      if (in_ready !== (q.size() < 4) || in_ready8 !== in_ready)
        $display("FAIL rand_in_ready cycle %0d got %0b/%0b want %0b", c, in_ready, in_ready8, (q.size() < 4));
      else passed++;
      if (in_valid && !in_ready) m_err = 1'b1;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL rand_unexpected_pop cycle %0d got r=%0d want nothing", c, out_result);
        end else begin
          e = q.pop_front();
          if (out_result !== e.r || out_acc !== e.a16 || out_valid8 !== 1'b1 || out_result8 !== e.r || out_acc8 !== e.a8)
            $display("FAIL rand_pop cycle %0d got r=%0d acc=%0d acc8=%0d want r=%0d acc=%0d acc8=%0d",
                     c, out_result, out_acc, out_acc8, e.r, e.a16, e.a8);
          else passed++;
        end
      end
      if (in_valid && in_ready) begin
        m_acc = m_acc + int'(a) + int'(b) + int'(cin);
        e.r   = 5'(int'(a) + int'(b) + int'(cin));
        e.a16 = 16'(m_acc);
        e.a8  = 8'(m_acc);
        q.push_back(e);
      end
      @(posedge clock);
      #1;
    end
    checks++; if (q.size() != 0) $display("FAIL rand_drain got %0d left want 0", q.size()); else passed++;
    checks++; if (issue_err !== m_err || issue_err8 !== m_err) $display("FAIL rand_issue_err got %0b want %0b", issue_err, m_err); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
    test_carry;
    test_backpressure;
    test_wrap;
    test_clear_capture;
    test_reset_midflight;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
